dma_copy: RTL and testbench

- Memory-to-memory DMA engine for the MCU bus.
- Appears to the CPU as an 8-register peripheral (slave port: AD/DI/DO/rw/cs). Once started, it becomes the bus initiator: it requests the bus, then drives address, data and read/write exactly as the CPU would toward SRAM and peripherals.
- Supports block copy and fill. Raises an interrupt when done.
- Decoded in the $FFE0 peripheral window alongside uart, gpio and timer. Its master port is muxed against the CPU by top-level bus arbitration.

---
 rtl/dma_copy_if.sv | 20 ++
 rtl/dma_copy.sv | 177 +++++++++++++++++
 tb/tb_dma_copy.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_if.sv
// dma_copy_if: bus-master port of the DMA engine.
// Request/grant handshake plus the address/data/direction bus.
interface dma_copy_if;
    logic        busreq;
    logic        busgrant;
    logic [15:0] m_address;
    logic [7:0]  m_dout;
    logic [7:0]  m_din;
    logic        m_read;

    modport master (
        output busreq, m_address, m_dout, m_read,
        input  busgrant, m_din
    );

    modport slave (
        input  busreq, m_address, m_dout, m_read,
        output busgrant, m_din
    );
endinterface

// File: rtl/dma_copy.sv
// dma_copy: memory-to-memory DMA (copy / fill) with an 8-register
// CPU slave port and a bus-master port toward SRAM and peripherals.
module dma_copy (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       intr,
    dma_copy_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_FIN
    } state_t;

    state_t      state, state_n;
    logic [15:0] src, dst, len;
    logic [7:0]  fill, buffer;
    logic        src_fix, dst_fix, fillmode, ie, done, abort_pend;
    logic        busy, wr_en, ctrl_wr, reg_wr, start;
    logic        abort_wr, abort_any;
    logic        step, cap, set_done;
    logic        busreq, m_read;
    logic [15:0] m_address;
    logic [7:0]  m_dout;

    assign busy = (state == S_REQ) || (state == S_RD) ||
                  (state == S_CAP) || (state == S_WR);

    assign wr_en   = cs & ~rw;
    assign ctrl_wr = wr_en & (AD == 3'd6);
    assign reg_wr  = wr_en & (AD != 3'd6) & ~busy;
    // ABORT together with START while idle cancels both.
    assign start     = ctrl_wr & ~busy & DI[0] & ~DI[6];
    assign abort_wr  = ctrl_wr & busy & DI[6];
    assign abort_any = abort_pend | abort_wr;

    assign bus.busreq    = busreq;
    assign bus.m_read    = m_read;
    assign bus.m_address = m_address;
    assign bus.m_dout    = m_dout;
    assign intr          = done & ie;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and master bus outputs; bus idles unless granted.
    always_comb begin
        state_n   = state;
        busreq    = 1'b0;
        m_read    = 1'b1;
        m_address = 16'h0000;
        m_dout    = 8'h00;
        step      = 1'b0;
        cap       = 1'b0;
        set_done  = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                if (state == S_FIN) begin
                    set_done = 1'b1;
                    state_n  = S_IDLE;
                end
                if (start) begin
                    if (len != 16'h0000) state_n  = S_REQ;
                    else                 set_done = 1'b1;
                end
            end
            S_REQ: begin
                busreq = 1'b1;
                if (abort_any)     state_n = S_FIN;
                else if (bus.busgrant)
                    state_n = fillmode ? S_WR : S_RD;
            end
            S_RD: begin
                busreq = 1'b1;
                if (!bus.busgrant) begin
                    if (abort_any) state_n = S_FIN;
                end else begin
                    m_address = src;
                    state_n   = S_CAP;
                end
            end
            S_CAP: begin
                busreq = 1'b1;
                if (!bus.busgrant) begin
                    state_n = abort_any ? S_FIN : S_RD;
                end else begin
                    cap     = 1'b1;
                    state_n = S_WR;
                end
            end
            S_WR: begin
                busreq = 1'b1;
                if (!bus.busgrant) begin
                    if (abort_any) state_n = S_FIN;
                end else begin
                    m_read    = 1'b0;
                    m_address = dst;
                    m_dout    = fillmode ? fill : buffer;
                    step      = 1'b1;
                    if (len == 16'h0001 || abort_any) state_n = S_FIN;
                    else state_n = fillmode ? S_WR : S_RD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Register file, address/length stepping, data buffer and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src        <= 16'h0000;
            dst        <= 16'h0000;
            len        <= 16'h0000;
            fill       <= 8'h00;
            buffer     <= 8'h00;
            src_fix    <= 1'b0;
            dst_fix    <= 1'b0;
            fillmode   <= 1'b0;
            ie         <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (AD)
                    3'd0:    src[15:8] <= DI;
                    3'd1:    src[7:0]  <= DI;
                    3'd2:    dst[15:8] <= DI;
                    3'd3:    dst[7:0]  <= DI;
                    3'd4:    len[15:8] <= DI;
                    3'd5:    len[7:0]  <= DI;
                    3'd7:    fill      <= DI;
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                ie <= DI[7];
                if (!busy) begin
                    src_fix  <= DI[1];
                    dst_fix  <= DI[2];
                    fillmode <= DI[3];
                end
            end
            if (step) begin
                if (!src_fix && !fillmode) src <= src + 16'd1;
                if (!dst_fix)              dst <= dst + 16'd1;
                len <= len - 16'd1;
            end
            if (cap) buffer <= bus.m_din;
            if (set_done)     done <= 1'b1;
            else if (ctrl_wr) done <= 1'b0;
            if (state == S_FIN) abort_pend <= 1'b0;
            else if (abort_wr)  abort_pend <= 1'b1;
        end
    end

    // Live register readback.
    always_comb begin
        DO = 8'h00;
        case (AD)
            3'd0: DO = src[15:8];
            3'd1: DO = src[7:0];
            3'd2: DO = dst[15:8];
            3'd3: DO = dst[7:0];
            3'd4: DO = len[15:8];
            3'd5: DO = len[7:0];
            3'd6: DO = {ie, 2'b00, fillmode, dst_fix, src_fix, done, busy};
            3'd7: DO = fill;
            default: DO = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed and randomized checks of dma_copy against
// a sequential byte-copy reference model and a 64K SRAM model.
module tb_dma_copy;
    logic       clk, rst;
    logic [2:0] AD;
    logic [7:0] DI, DO;
    logic       rw, cs, intr;
    logic       gnt_en, gnt_drop, rnd_mode;
    logic       rnd_g = 1'b1;
    logic [7:0] m_din_q = 8'h00;
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic       breq_hist [0:4095];
    int         cyc = 0, breq_cnt = 0, n_chk = 0, n_fail = 0;
    typedef struct { int cyc; logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t         wr_log[$];
    logic [15:0] rd_log[$];

    dma_copy_if bus();
    assign bus.busgrant = gnt_en & ~gnt_drop & (rnd_mode ? rnd_g : 1'b1);
    assign bus.m_din    = m_din_q;

    dma_copy dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
        .rw(rw), .cs(cs), .intr(intr), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) rnd_g <= ($urandom_range(0, 3) != 0);

    // Synchronous SRAM plus bus activity logs.
    always @(posedge clk) begin
        m_din_q <= mem[bus.m_address];
        breq_hist[cyc % 4096] = bus.busreq;
        if (bus.busreq) breq_cnt++;
        if (bus.busgrant && bus.m_read && bus.m_address != 16'h0)
            rd_log.push_back(bus.m_address);
        if (bus.busgrant && !bus.m_read) begin
            mem[bus.m_address] = bus.m_dout;
            wr_log.push_back('{cyc, bus.m_address, bus.m_dout});
        end
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        AD = a;
        #1;
        d = DO;
    endtask

    task automatic chk16(input string tag, input logic [2:0] a,
                         input logic [15:0] exp);
        logic [7:0] h, l;
        rd_reg(a, h);
        rd_reg(a + 3'd1, l);
        check(tag, 32'({h, l}), 32'(exp));
    endtask

    task automatic chk_st(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(3'd6, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [7:0] f);
        cpu_wr(3'd0, s[15:8]); cpu_wr(3'd1, s[7:0]);
        cpu_wr(3'd2, d[15:8]); cpu_wr(3'd3, d[7:0]);
        cpu_wr(3'd4, l[15:8]); cpu_wr(3'd5, l[7:0]);
        cpu_wr(3'd7, f);
    endtask

    task automatic wait_done(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        AD = 3'd6;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            #1;
            if (!bus.busgrant && bus.busreq)
                check({tag, "_idle"},
                      {7'b0, bus.m_read, bus.m_address, bus.m_dout},
                      32'h0100_0000);
            if (DO[1]) ok = 1'b1;
        end
        check({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int n, cnt, snap;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0010 + i] = 8'(8'h11 * (i + 1));
            mem[16'h0100 + i] = 8'(8'h61 + i);
        end
        for (int i = 0; i < 10; i++) mem[16'h0200 + i] = 8'(8'h70 + i);
        mem[16'hFFFF] = 8'h5C;
        mem[16'h0000] = 8'hC5;
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        gnt_en = 1'b1; gnt_drop = 1'b0; rnd_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busreq", 32'(bus.busreq), 0);
        check("rst_mread", 32'(bus.m_read), 1);
        check("rst_maddr", 32'(bus.m_address), 0);
        check("rst_mdout", 32'(bus.m_dout), 0);
        check("rst_intr", 32'(intr), 0);
        for (int a = 0; a < 8; a++) begin
            AD = 3'(a);
            #1;
            check($sformatf("rst_reg%0d", a), 32'(DO), 0);
        end

        // Block copy.
        wr_log.delete();
        setup(16'h0010, 16'h0800, 16'd4, 8'h00);
        cpu_wr(3'd6, 8'h81);
        wait_done("cp", 100);
        check("cp_nwr", 32'(wr_log.size()), 4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cp_a%0d", i), 32'(wr_log[i].a),
                      32'(16'h0800 + i));
                check($sformatf("cp_d%0d", i), 32'(wr_log[i].d),
                      32'(8'h11 * (i + 1)));
                if (i > 0)
                    check($sformatf("cp_gap%0d", i),
                          32'(wr_log[i].cyc - wr_log[i-1].cyc), 3);
            end
            cnt = 0;
            for (int k = wr_log[0].cyc - 2; k <= wr_log[3].cyc; k++)
                cnt += int'(breq_hist[k % 4096]);
            check("cp_breq", 32'(cnt), 12);
            check("cp_breq_req", 32'(breq_hist[(wr_log[0].cyc - 3) % 4096]), 1);
            check("cp_breq_fin", 32'(breq_hist[(wr_log[3].cyc + 1) % 4096]), 0);
        end
        chk16("cp_src", 3'd0, 16'h0014);
        chk16("cp_dst", 3'd2, 16'h0804);
        chk16("cp_len", 3'd4, 16'h0000);
        chk_st("cp_stat", 8'h82);
        check("cp_intr", 32'(intr), 1);
        cpu_wr(3'd6, 8'h80);
        chk_st("cp_clr_stat", 8'h80);
        check("cp_clr_intr", 32'(intr), 0);

        // Fill with fixed destination.
        wr_log.delete();
        setup(16'h1234, 16'hFFE8, 16'd3, 8'hA5);
        cpu_wr(3'd6, 8'h0D);
        wait_done("fl", 100);
        check("fl_nwr", 32'(wr_log.size()), 3);
        if (wr_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("fl_a%0d", i), 32'(wr_log[i].a), 32'hFFE8);
                check($sformatf("fl_d%0d", i), 32'(wr_log[i].d), 32'hA5);
                if (i > 0)
                    check($sformatf("fl_gap%0d", i),
                          32'(wr_log[i].cyc - wr_log[i-1].cyc), 1);
            end
        end
        chk16("fl_src", 3'd0, 16'h1234);
        chk16("fl_dst", 3'd2, 16'hFFE8);
        chk16("fl_len", 3'd4, 16'h0000);
        chk_st("fl_stat", 8'h1A);

        // Address wrap.
        wr_log.delete();
        setup(16'hFFFF, 16'h07FF, 16'd2, 8'h00);
        cpu_wr(3'd6, 8'h01);
        wait_done("wp", 100);
        check("wp_nwr", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) begin
            check("wp_a0", 32'(wr_log[0].a), 32'h07FF);
            check("wp_d0", 32'(wr_log[0].d), 32'h5C);
            check("wp_a1", 32'(wr_log[1].a), 32'h0800);
            check("wp_d1", 32'(wr_log[1].d), 32'hC5);
        end
        chk16("wp_src", 3'd0, 16'h0001);
        chk16("wp_dst", 3'd2, 16'h0801);

        // Zero-length start.
        wr_log.delete();
        setup(16'h0500, 16'h0D00, 16'd0, 8'h00);
        cpu_wr(3'd6, 8'h00);
        chk_st("z_pre", 8'h00);
        snap = breq_cnt;
        cpu_wr(3'd6, 8'h01);
        chk_st("z_done", 8'h02);
        repeat (3) @(negedge clk);
        check("z_breq", 32'(breq_cnt - snap), 0);
        check("z_nwr", 32'(wr_log.size()), 0);

        // Grant drop during CAP of byte 2.
        wr_log.delete();
        rd_log.delete();
        setup(16'h0100, 16'h0900, 16'd4, 8'h00);
        cpu_wr(3'd6, 8'h01);
        n = 0;
        for (int k = 0; k < 100 && n < 2; k++) begin
            @(negedge clk);
            #1;
            if (!bus.m_read) n++;
        end
        check("gd_reach", 32'(n), 2);
        @(negedge clk);
        #1;
        check("gd_rd_addr", 32'(bus.m_address), 32'h0102);
        @(negedge clk);
        gnt_drop = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("gd_idle%0d", k),
                  {7'b0, bus.m_read, bus.m_address, bus.m_dout}, 32'h0100_0000);
            check($sformatf("gd_breq%0d", k), 32'(bus.busreq), 1);
            @(negedge clk);
            #1;
        end
        gnt_drop = 1'b0;
        wait_done("gd", 100);
        check("gd_nrd", 32'(rd_log.size()), 5);
        if (rd_log.size() == 5) begin
            check("gd_rd2", 32'(rd_log[2]), 32'h0102);
            check("gd_rd3", 32'(rd_log[3]), 32'h0102);
            check("gd_rd4", 32'(rd_log[4]), 32'h0103);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("gd_mem%0d", i), 32'(mem[16'h0900 + i]),
                  32'(8'h61 + i));

        // ABORT after byte 3's read.
        wr_log.delete();
        setup(16'h0200, 16'h0A00, 16'd10, 8'h00);
        cpu_wr(3'd6, 8'h01);
        n = 0;
        for (int k = 0; k < 100 && n < 3; k++) begin
            @(negedge clk);
            #1;
            if (!bus.m_read) n++;
        end
        check("ab_reach", 32'(n), 3);
        @(negedge clk);
        #1;
        check("ab_rd_addr", 32'(bus.m_address), 32'h0203);
        cpu_wr(3'd6, 8'h40);
        wait_done("ab", 100);
        check("ab_nwr", 32'(wr_log.size()), 4);
        chk16("ab_len", 3'd4, 16'd6);
        chk16("ab_src", 3'd0, 16'h0204);
        chk_st("ab_stat", 8'h02);
        for (int i = 0; i < 4; i++)
            check($sformatf("ab_mem%0d", i), 32'(mem[16'h0A00 + i]),
                  32'(8'h70 + i));

        // ABORT while waiting for grant.
        wr_log.delete();
        gnt_en = 1'b0;
        setup(16'h0300, 16'h0B00, 16'd5, 8'h00);
        cpu_wr(3'd6, 8'h01);
        repeat (3) @(negedge clk);
        #1;
        check("ar_breq", 32'(bus.busreq), 1);
        cpu_wr(3'd6, 8'h40);
        wait_done("ar", 20);
        chk16("ar_len", 3'd4, 16'd5);
        check("ar_nwr", 32'(wr_log.size()), 0);
        check("ar_breq_off", 32'(bus.busreq), 0);
        gnt_en = 1'b1;

        // ABORT with START while idle.
        snap = breq_cnt;
        cpu_wr(3'd6, 8'h41);
        repeat (4) @(negedge clk);
        check("as_breq", 32'(breq_cnt - snap), 0);
        chk_st("as_stat", 8'h00);

        // Randomized copies and fills under random grant.
        rnd_mode = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        for (int t = 0; t < 15; t++) begin
            logic [15:0] s, d, l, ea, sa;
            logic        sf, df, fm, ie;
            logic [7:0]  fv, ed;
            s  = 16'h1000 + 16'($urandom_range(1, 255));
            d  = 16'h1000 + 16'($urandom_range(1, 255));
            l  = 16'($urandom_range(1, 12));
            sf = 1'($urandom_range(0, 1));
            df = 1'($urandom_range(0, 1));
            fm = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            fv = 8'($urandom);
            wr_log.delete();
            setup(s, d, l, fv);
            cpu_wr(3'd6, {ie, 3'b000, fm, df, sf, 1'b1});
            wait_done($sformatf("r%0d", t), 500);
            check($sformatf("r%0d_nwr", t), 32'(wr_log.size()), 32'(l));
            for (int i = 0; i < int'(l); i++) begin
                ea = d + (df ? 16'd0 : 16'(i));
                sa = s + ((sf || fm) ? 16'd0 : 16'(i));
                ed = fm ? fv : ref_mem[sa];
                ref_mem[ea] = ed;
                if (i < wr_log.size()) begin
                    check($sformatf("r%0d_a%0d", t, i), 32'(wr_log[i].a),
                          32'(ea));
                    check($sformatf("r%0d_d%0d", t, i), 32'(wr_log[i].d),
                          32'(ed));
                end
            end
            chk16($sformatf("r%0d_src", t), 3'd0,
                  s + ((sf || fm) ? 16'd0 : l));
            chk16($sformatf("r%0d_dst", t), 3'd2, d + (df ? 16'd0 : l));
            chk16($sformatf("r%0d_len", t), 3'd4, 16'd0);
            chk_st($sformatf("r%0d_st", t),
                   {ie, 2'b00, fm, df, sf, 1'b1, 1'b0});
            check($sformatf("r%0d_intr", t), 32'(intr), 32'(ie));
        end
        rnd_mode = 1'b0;

        // Asynchronous reset in the middle of a write.
        setup(16'h0400, 16'h0C00, 16'd4, 8'h00);
        cpu_wr(3'd6, 8'h81);
        n = 0;
        for (int k = 0; k < 100 && n < 1; k++) begin
            @(negedge clk);
            #1;
            if (!bus.m_read) n++;
        end
        check("rs_reach", 32'(n), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_breq", 32'(bus.busreq), 0);
        check("rs_mread", 32'(bus.m_read), 1);
        check("rs_maddr", 32'(bus.m_address), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            AD = 3'(a);
            #1;
            check($sformatf("rs_reg%0d", a), 32'(DO), 0);
        end
        check("rs_intr", 32'(intr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
